// File: rtl/fifo_ctl_pkg.sv
// Control-path types shared by the FIFO write scheduler and a future read-side scheduler.
package fifo_ctl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_BURST      = 2'd1,
    ST_FLUSH      = 2'd2,
    ST_FLUSH_WAIT = 2'd3
  } arb_state_t;

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Requester bus plus FIFO write-port signals of the write scheduler.
interface fifo_write_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4
);

  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       in_valid;
  logic [NREQ-1:0]       in_last;
  logic [NREQ*WIDTH-1:0] in_data;
  logic [NREQ-1:0]       grant;
  logic                  fifo_ready;
  logic                  fifo_active;
  logic                  wr_en;
  logic [WIDTH-1:0]      wr_data;
  logic                  fifo_reset;

  // Scheduler side.
  modport master (
    input  req, in_valid, in_last, in_data, fifo_ready, fifo_active,
    output grant, wr_en, wr_data, fifo_reset
  );

  // Requesters and FIFO side.
  modport slave (
    output req, in_valid, in_last, in_data, fifo_ready, fifo_active,
    input  grant, wr_en, wr_data, fifo_reset
  );

endinterface

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after start, wrapping modulo NREQ.
module rr_pick #(
  parameter  int NREQ = 4,
  localparam int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   start,
  output logic [NREQ-1:0] pick,
  output logic [PW-1:0]   idx,
  output logic            found
);

  logic [PW:0] pos_s;

  // Scan candidates in priority order; the sum never exceeds 2*NREQ-2 so one subtract wraps it.
  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    pos_s = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos_s = {1'b0, start} + (PW+1)'(k);
      if (pos_s >= (PW+1)'(NREQ)) begin
        pos_s = pos_s - (PW+1)'(NREQ);
      end else begin
        pos_s = pos_s;
      end
      if (!found && req[pos_s[PW-1:0]]) begin
        found                 = 1'b1;
        pick[pos_s[PW-1:0]]   = 1'b1;
        idx                   = pos_s[PW-1:0];
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst scheduler sharing one async-FIFO write port among NREQ requesters,
// granting only while the FIFO can absorb a full burst, and sequencing FIFO flushes.
module fifo_write_arbiter
  import fifo_ctl_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int NREQ  = 4,
  parameter  int BURST = 16,
  localparam int PW    = $clog2(NREQ),
  localparam int CW    = $clog2(BURST + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  output logic                 busy,
  output logic                 abort,
  fifo_write_arbiter_if.master bus
);

  arb_state_t       state_r, state_n;
  logic [PW-1:0]    rr_ptr_r, rr_ptr_n;
  logic [PW-1:0]    gidx_r, gidx_n;
  logic [CW-1:0]    cnt_r, cnt_n;
  logic [NREQ-1:0]  grant_r, grant_n;
  logic             flush_pend_r, flush_pend_n;
  logic             seen_low_r, seen_low_n;
  logic             wr_en_r, wr_en_n;
  logic [WIDTH-1:0] wr_data_r, wr_data_n;
  logic             fifo_reset_r, fifo_reset_n;
  logic             abort_r, abort_n;
  logic             busy_r;

  logic [NREQ-1:0]  pick_s;
  logic [PW-1:0]    pick_idx_s;
  logic             pick_found_s;
  logic [PW-1:0]    next_ptr_s;
  logic [WIDTH-1:0] sel_data_s;
  logic             sel_valid_s;
  logic             sel_last_s;
  logic             accept_s;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req   (bus.req),
    .start (rr_ptr_r),
    .pick  (pick_s),
    .idx   (pick_idx_s),
    .found (pick_found_s)
  );

  // Lanes of the currently granted requester; everyone else is ignored.
  always_comb begin
    sel_data_s  = '0;
    sel_valid_s = 1'b0;
    sel_last_s  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gidx_r == PW'(i)) begin
        sel_data_s  = bus.in_data[i*WIDTH +: WIDTH];
        sel_valid_s = bus.in_valid[i];
        sel_last_s  = bus.in_last[i];
      end else begin
        sel_data_s  = sel_data_s;
      end
    end
  end

  assign accept_s   = sel_valid_s & grant_r[gidx_r];
  assign next_ptr_s = (gidx_r == PW'(NREQ - 1)) ? '0 : gidx_r + PW'(1);

  // Next-state, grant bookkeeping and write-port values.
  always_comb begin
    state_n      = state_r;
    rr_ptr_n     = rr_ptr_r;
    gidx_n       = gidx_r;
    cnt_n        = cnt_r;
    grant_n      = grant_r;
    flush_pend_n = flush_pend_r;
    seen_low_n   = seen_low_r;
    wr_en_n      = 1'b0;
    wr_data_n    = wr_data_r;
    fifo_reset_n = 1'b0;
    abort_n      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (flush || flush_pend_r) begin
          state_n = ST_FLUSH;
        end else if (bus.fifo_ready && bus.fifo_active && pick_found_s) begin
          grant_n = pick_s;
          gidx_n  = pick_idx_s;
          cnt_n   = '0;
          state_n = ST_BURST;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (flush) begin
          flush_pend_n = 1'b1;
        end else begin
          flush_pend_n = flush_pend_r;
        end
        // Losing fifo_active means the FIFO is being reset under us: drop the word and release.
        if (!bus.fifo_active) begin
          grant_n  = '0;
          abort_n  = 1'b1;
          rr_ptr_n = next_ptr_s;
          state_n  = ST_IDLE;
        end else if (accept_s) begin
          wr_en_n   = 1'b1;
          wr_data_n = sel_data_s;
          cnt_n     = cnt_r + CW'(1);
          if (sel_last_s || (cnt_r == CW'(BURST - 1))) begin
            grant_n  = '0;
            rr_ptr_n = next_ptr_s;
            state_n  = ST_IDLE;
          end else begin
            state_n  = ST_BURST;
          end
        end else begin
          state_n = ST_BURST;
        end
      end
      ST_FLUSH: begin
        fifo_reset_n = 1'b1;
        flush_pend_n = 1'b0;
        seen_low_n   = 1'b0;
        state_n      = ST_FLUSH_WAIT;
      end
      ST_FLUSH_WAIT: begin
        if (!bus.fifo_active) begin
          seen_low_n = 1'b1;
        end else if (seen_low_r) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_FLUSH_WAIT;
        end
      end
      default: begin
        grant_n = '0;
        state_n = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Pointers, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_r     <= '0;
      gidx_r       <= '0;
      cnt_r        <= '0;
      grant_r      <= '0;
      flush_pend_r <= 1'b0;
      seen_low_r   <= 1'b0;
      wr_en_r      <= 1'b0;
      wr_data_r    <= '0;
      fifo_reset_r <= 1'b0;
      abort_r      <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      rr_ptr_r     <= rr_ptr_n;
      gidx_r       <= gidx_n;
      cnt_r        <= cnt_n;
      grant_r      <= grant_n;
      flush_pend_r <= flush_pend_n;
      seen_low_r   <= seen_low_n;
      wr_en_r      <= wr_en_n;
      wr_data_r    <= wr_data_n;
      fifo_reset_r <= fifo_reset_n;
      abort_r      <= abort_n;
      busy_r       <= (state_n != ST_IDLE);
    end
  end

  assign bus.grant      = grant_r;
  assign bus.wr_en      = wr_en_r;
  assign bus.wr_data    = wr_data_r;
  assign bus.fifo_reset = fifo_reset_r;
  assign busy           = busy_r;
  assign abort          = abort_r;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: requester/FIFO emulation, a per-cycle reference model
// and literal expectations for each scenario.
module tb_fifo_write_arbiter;

  localparam int WIDTH = 16;
  localparam int NREQ  = 4;
  localparam int BURST = 16;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  logic busy;
  logic abort;

  always #5 clk = ~clk;

  fifo_write_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  fifo_write_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .BURST(BURST)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .busy  (busy),
    .abort (abort),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int               m_owner = -1;   // requester holding the port, -1 when none
  int               m_words = 0;    // words taken in the current burst
  int               m_ptr   = 0;    // requester to favour next
  bit               m_pend  = 1'b0; // flush waiting for the burst to finish
  int               m_phase = 0;    // 0 none, 1 pulse reset, 2 wait low, 3 wait high
  logic [NREQ-1:0]  e_grant;
  logic             e_wr_en, e_fifo_reset, e_busy, e_abort;
  logic [WIDTH-1:0] e_wr_data;

  task automatic model_step();
    e_wr_en = 1'b0; e_fifo_reset = 1'b0; e_abort = 1'b0;
    if (reset) begin
      m_owner = -1; m_words = 0; m_ptr = 0; m_pend = 1'b0; m_phase = 0; e_wr_data = '0;
    end else if (m_phase == 1) begin
      e_fifo_reset = 1'b1; m_pend = 1'b0; m_phase = 2;
    end else if (m_phase == 2) begin
      if (!bus.fifo_active) m_phase = 3;
    end else if (m_phase == 3) begin
      if (bus.fifo_active) m_phase = 0;
    end else if (m_owner >= 0) begin
      if (flush) m_pend = 1'b1;
      if (!bus.fifo_active) begin
        e_abort = 1'b1; m_ptr = (m_owner + 1) % NREQ; m_owner = -1;
      end else if (bus.in_valid[m_owner]) begin
        e_wr_en = 1'b1; e_wr_data = bus.in_data[m_owner*WIDTH +: WIDTH]; m_words++;
        if (bus.in_last[m_owner] || m_words == BURST) begin
          m_ptr = (m_owner + 1) % NREQ; m_owner = -1;
        end
      end
    end else begin
      if (flush || m_pend) m_phase = 1;
      else if (bus.fifo_ready && bus.fifo_active && bus.req != '0) begin
        for (int k = 0; k < NREQ; k++) begin
          int c;
          c = (m_ptr + k) % NREQ;
          if (m_owner < 0 && bus.req[c]) begin m_owner = c; m_words = 0; end
        end
      end
    end
    e_grant = '0;
    if (m_owner >= 0) e_grant[m_owner] = 1'b1;
    e_busy = (m_owner >= 0) || (m_phase != 0);
  endtask

  // ---------------- compare process and event logs ----------------
  logic [WIDTH-1:0] wlog[$];
  int               glog[$];
  int               gtime[$];
  int               gcyc[NREQ];
  int               n_freset, wr_at_freset, n_abort;
  int               cyc = 0;
  logic [NREQ-1:0]  prev_grant = '0;

  always @(posedge clk) begin
    model_step();
    #1;
    cyc++;
    chk("grant",      32'(bus.grant),      32'(e_grant));
    chk("wr_en",      32'(bus.wr_en),      32'(e_wr_en));
    chk("wr_data",    32'(bus.wr_data),    32'(e_wr_data));
    chk("fifo_reset", 32'(bus.fifo_reset), 32'(e_fifo_reset));
    chk("busy",       32'(busy),           32'(e_busy));
    chk("abort",      32'(abort),          32'(e_abort));
    if (bus.wr_en === 1'b1) wlog.push_back(bus.wr_data);
    if (bus.grant != '0 && bus.grant != prev_grant) begin
      for (int i = 0; i < NREQ; i++) if (bus.grant[i]) glog.push_back(i);
      gtime.push_back(cyc);
    end
    for (int i = 0; i < NREQ; i++) if (bus.grant[i] === 1'b1) gcyc[i]++;
    if (bus.fifo_reset === 1'b1) begin n_freset++; wr_at_freset = wlog.size(); end
    if (abort === 1'b1) n_abort++;
    prev_grant = bus.grant;
  end

  function automatic int gl(input int k);
    return (k < glog.size()) ? glog[k] : -1;
  endfunction

  function automatic logic [31:0] wl(input int k);
    return (k < wlog.size()) ? 32'(wlog[k]) : 32'hDEAD_BEEF;
  endfunction

  task automatic clear_logs();
    wlog.delete(); glog.delete(); gtime.delete();
    for (int i = 0; i < NREQ; i++) gcyc[i] = 0;
    n_freset = 0; wr_at_freset = 0; n_abort = 0;
  endtask

  // ---------------- requester emulation ----------------
  int              sent[NREQ];
  int              len[NREQ];   // 0: never raise in_last
  logic [NREQ-1:0] gprev = '0;

  task automatic step();
    @(negedge clk);
    for (int i = 0; i < NREQ; i++)
      if (gprev[i] && bus.fifo_active && !reset) sent[i]++;
    gprev = bus.grant;
    for (int i = 0; i < NREQ; i++) begin
      bus.in_valid[i] = 1'b1;
      if (gprev[i]) begin
        bus.in_data[i*WIDTH +: WIDTH] = 16'(i * 4096 + sent[i]);
        bus.in_last[i] = (len[i] != 0) && (sent[i] == len[i] - 1);
      end else begin
        bus.in_data[i*WIDTH +: WIDTH] = 16'(32'hBAD0 + i);
        bus.in_last[i] = 1'b1;
      end
    end
  endtask

  task automatic step_n(input int n);
    for (int s = 0; s < n; s++) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step_n(2);
    reset = 1'b0;
    for (int i = 0; i < NREQ; i++) begin sent[i] = 0; len[i] = 0; end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    bus.req = '0; bus.in_valid = '0; bus.in_last = '0; bus.in_data = '0;
    bus.fifo_ready = 1'b1; bus.fifo_active = 1'b1;
    for (int i = 0; i < NREQ; i++) begin sent[i] = 0; len[i] = 0; end
    step_n(3);
    chk("rst_grant", 32'(bus.grant), 32'h0);
    chk("rst_wr_en", 32'(bus.wr_en), 32'h0);
    chk("rst_busy",  32'(busy),      32'h0);
    reset = 1'b0;

    // Single requester, 5-word burst, req dropped mid-burst.
    clear_logs();
    len[0] = 5; bus.req = 4'b0001;
    step_n(3);
    bus.req = 4'b0000;
    step_n(10);
    chk("single_writes", 32'(wlog.size()), 32'd5);
    for (int k = 0; k < 5; k++) chk("single_data", wl(k), 32'(k));
    chk("single_gcyc",   32'(gcyc[0]), 32'd5);
    chk("single_grants", 32'(glog.size()), 32'd1);
    chk("single_busy",   32'(busy), 32'h0);

    // Contention: all requesting, full-length bursts.
    do_reset(); clear_logs();
    bus.req = 4'b1111;
    for (int s = 0; s < 150 && glog.size() < 5; s++) step();
    bus.req = 4'b0000;
    step_n(20);
    chk("rr_count", 32'(glog.size()), 32'd5);
    chk("rr_g0", 32'(gl(0)), 32'd0);
    chk("rr_g1", 32'(gl(1)), 32'd1);
    chk("rr_g2", 32'(gl(2)), 32'd2);
    chk("rr_g3", 32'(gl(3)), 32'd3);
    chk("rr_g4", 32'(gl(4)), 32'd0);
    chk("rr_writes", 32'(wlog.size()), 32'd80);
    chk("rr_gcyc0", 32'(gcyc[0]), 32'd32);
    chk("rr_gcyc3", 32'(gcyc[3]), 32'd16);
    chk("rr_period", (gtime.size() == 5) ? 32'(gtime[4] - gtime[0]) : 32'hFFFF_FFFF, 32'd68);

    // Backpressure: no grant while fifo_ready is low.
    do_reset(); clear_logs();
    bus.fifo_ready = 1'b0; len[0] = 2; bus.req = 4'b0001;
    step_n(5);
    chk("bp_nogrant", 32'(bus.grant), 32'h0);
    chk("bp_busy",    32'(busy),      32'h0);
    bus.fifo_ready = 1'b1;
    step();
    chk("bp_grant", 32'(bus.grant), 32'h1);
    bus.req = 4'b0000;
    step_n(6);
    chk("bp_writes", 32'(wlog.size()), 32'd2);

    // Flush during an 8-word burst.
    do_reset(); clear_logs();
    len[0] = 8; bus.req = 4'b0001;
    for (int s = 0; s < 20 && sent[0] != 3; s++) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int s = 0; s < 30 && n_freset == 0; s++) step();
    chk("fl_writes_before_reset", 32'(wr_at_freset), 32'd8);
    chk("fl_pulses", 32'(n_freset), 32'd1);
    step_n(2);
    bus.fifo_active = 1'b0;
    step_n(13);
    chk("fl_busy_wait", 32'(busy), 32'h1);
    bus.fifo_active = 1'b1;
    chk("fl_no_regrant", 32'(glog.size()), 32'd1);
    sent[0] = 0;
    step_n(4);
    chk("fl_regrant", 32'(glog.size()), 32'd2);
    bus.req = 4'b0000;
    step_n(12);
    chk("fl_single_pulse", 32'(n_freset), 32'd1);

    // Abort: fifo_active drops while the 4th word is presented.
    do_reset(); clear_logs();
    len[1] = 8; bus.req = 4'b0010;
    for (int s = 0; s < 20 && sent[1] != 3; s++) step();
    bus.fifo_active = 1'b0;
    step();
    chk("ab_pulse", 32'(abort),     32'h1);
    chk("ab_grant", 32'(bus.grant), 32'h0);
    bus.req = 4'b0000;
    step();
    chk("ab_pulse_end", 32'(abort), 32'h0);
    bus.fifo_active = 1'b1;
    step_n(2);
    chk("ab_writes", 32'(wlog.size()), 32'd3);
    chk("ab_d0", wl(0), 32'h1000);
    chk("ab_d2", wl(2), 32'h1002);
    chk("ab_count", 32'(n_abort), 32'd1);
    for (int i = 0; i < NREQ; i++) begin len[i] = 1; sent[i] = 0; end
    bus.req = 4'b1111;
    step();
    bus.req = 4'b0000;
    step_n(4);
    chk("ab_first", 32'(gl(0)), 32'd1);
    chk("ab_next",  32'(gl(1)), 32'd2);

    // Reset in the middle of a burst.
    do_reset(); clear_logs();
    len[2] = 8; bus.req = 4'b0100;
    for (int s = 0; s < 20 && sent[2] != 2; s++) step();
    reset = 1'b1;
    step();
    chk("mr_grant", 32'(bus.grant), 32'h0);
    chk("mr_wr_en", 32'(bus.wr_en), 32'h0);
    chk("mr_busy",  32'(busy),      32'h0);
    reset = 1'b0;
    for (int i = 0; i < NREQ; i++) begin len[i] = 1; sent[i] = 0; end
    bus.req = 4'b1111;
    step();
    bus.req = 4'b0000;
    step_n(4);
    chk("mr_grants", 32'(glog.size()), 32'd2);
    chk("mr_after",  32'(gl(1)), 32'd0);

    step_n(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
